trace_capture: RTL and testbench



---
 rtl/trace_pkg.sv | 25 ++
 rtl/trace_ram.sv | 46 ++++
 rtl/trace_capture.sv | 147 ++++++++++++++
 tb/tb_trace_capture.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// ============================================================================
// Module      : trace_pkg
// Description : Shared state encoding and trigger-mode constants for the
//               trace capture block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] c_trig_immediate = 2'd0;
    localparam logic [1:0] c_trig_match     = 2'd1;
    localparam logic [1:0] c_trig_change    = 2'd2;
    localparam logic [1:0] c_trig_reserved  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/trace_ram.sv
// ============================================================================
// Module      : trace_ram
// Description : DEPTH x WIDTH simple dual-port RAM, synchronous write and
//               registered read port that holds its value when not read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_ram #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage array is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/trace_capture.sv
// ============================================================================
// Module      : trace_capture
// Description : Arm/trigger/capture controller that stores DEPTH valid
//               samples after a selectable trigger and drains them in order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_capture #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    parameter int TSW   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       sample_in,
    input  logic                   sample_valid,
    input  logic                   arm,
    input  logic [1:0]             trig_mode,
    input  logic [WIDTH-1:0]       trig_value,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] count,
    output logic [TSW-1:0]         trig_ts
);

    import trace_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_last = CW'(DEPTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_prev;
    logic             r_has_prev;
    logic [TSW-1:0]   r_trig_ts;
    logic             r_rd_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_trig;
    logic             w_we;
    logic             w_rd_ok;

    always_comb begin
        w_trig = 1'b0;
        if (sample_valid) begin
            case (trig_mode)
                c_trig_match:  w_trig = (sample_in == trig_value);
                c_trig_change: w_trig = r_has_prev && (sample_in != r_prev);
                default:       w_trig = 1'b1;
            endcase
        end
    end

    // The write address is the running count: it is 0 on the trigger
    // sample and never reaches DEPTH while a write is possible.
    assign w_we    = ((r_state == ST_ARMED) && w_trig) ||
                     ((r_state == ST_CAPTURE) && sample_valid);
    assign w_rd_ok = (r_state == ST_DONE) && rd_en && !arm && (r_rd_ptr < r_count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_prev     <= '0;
            r_has_prev <= 1'b0;
            r_trig_ts  <= '0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        r_state    <= ST_ARMED;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_count    <= '0;
                        r_rd_ptr   <= '0;
                        r_has_prev <= 1'b0;
                        r_trig_ts  <= '0;
                    end else if (w_rd_ok) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (r_trig_ts != '1) begin
                        r_trig_ts <= r_trig_ts + 1'b1;
                    end
                    if (sample_valid) begin
                        r_prev     <= sample_in;
                        r_has_prev <= 1'b1;
                    end
                    if (w_trig) begin
                        r_count <= CW'(1);
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid) begin
                        r_count <= r_count + 1'b1;
                        if (r_count == c_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    trace_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_count[AW-1:0]),
        .i_wdata (sample_in),
        .i_re    (w_rd_ok),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (rd_data)
    );

    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign count    = r_count;
    assign trig_ts  = r_trig_ts;

endmodule

`default_nettype wire

// File: tb/tb_trace_capture.sv
// ============================================================================
// Module      : tb_trace_capture
// Description : Self-checking bench for trace_capture: vector table for a
//               mode-0 capture/drain plus directed trigger and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trace_capture;

    localparam int WIDTH = 4;
    localparam int DEPTH = 16;
    localparam int TSW   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] sample_in = '0;
    logic             sample_valid = 1'b0;
    logic             arm = 1'b0;
    logic [1:0]       trig_mode = 2'd0;
    logic [WIDTH-1:0] trig_value = '0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             busy;
    logic             done;
    logic [4:0]       count;
    logic [TSW-1:0]   trig_ts;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    trace_capture #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .TSW   (TSW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .arm          (arm),
        .trig_mode    (trig_mode),
        .trig_value   (trig_value),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .done         (done),
        .count        (count),
        .trig_ts      (trig_ts)
    );

    typedef struct {
        logic       arm;
        logic       valid;
        logic [3:0] sample;
        logic       rd_en;
        logic       busy;
        logic       done;
        logic [4:0] count;
        logic       rd_valid;
        logic       chk_data;
        logic [3:0] rd_data;
        logic [3:0] ts;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic a, logic v, logic [3:0] s, logic r,
                                logic b, logic d, logic [4:0] c, logic rv,
                                logic cd, logic [3:0] rdd, logic [3:0] ts);
        vec_t x;
        x.arm = a; x.valid = v; x.sample = s; x.rd_en = r;
        x.busy = b; x.done = d; x.count = c; x.rd_valid = rv;
        x.chk_data = cd; x.rd_data = rdd; x.ts = ts;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic v, input logic [3:0] s, input logic r);
        arm = a; sample_valid = v; sample_in = s; rd_en = r;
    endtask

    initial begin
        // Table: mode-0 capture of 0..15, full drain, over-read, arm+rd_en,
        // and arm ignored during a second capture.
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 1, 4'(i), 0, i < 15, i == 15, 5'(i + 1), 0, 0, 0, 1));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 0, 0, 1, 0, 1, 16, 1, 1, 4'(i), 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 16, 0, 1, 15, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 7, 0, 1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 8, 0, 1, 0, 2, 0, 0, 0, 1));
        for (int i = 0; i < 14; i++)
            vecs.push_back(mk(0, 1, 4'(i), 0, i < 13, i == 13, 5'(3 + i), 0, 0, 0, 1));

        // Reset state
        repeat (2) step();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset count", count, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset trig_ts", trig_ts, 0);
        rst = 1'b0;
        step();

        trig_mode = 2'd0;
        foreach (vecs[k]) begin
            drive(vecs[k].arm, vecs[k].valid, vecs[k].sample, vecs[k].rd_en);
            step();
            chk($sformatf("vec%0d busy", k), busy, vecs[k].busy);
            chk($sformatf("vec%0d done", k), done, vecs[k].done);
            chk($sformatf("vec%0d count", k), count, vecs[k].count);
            chk($sformatf("vec%0d rd_valid", k), rd_valid, vecs[k].rd_valid);
            chk($sformatf("vec%0d trig_ts", k), trig_ts, vecs[k].ts);
            if (vecs[k].chk_data)
                chk($sformatf("vec%0d rd_data", k), rd_data, vecs[k].rd_data);
        end

        // Mode 1: arm coincident with a matching sample must not trigger.
        trig_mode = 2'd1; trig_value = 4'hA;
        drive(1, 1, 4'hA, 0); step();
        chk("m1 arm count", count, 0);
        chk("m1 arm busy", busy, 1);
        drive(0, 1, 4'h3, 0); step();
        drive(0, 0, 4'hA, 0); step();
        drive(0, 1, 4'h7, 0); step();
        chk("m1 pre count", count, 0);
        drive(0, 1, 4'hA, 0); step();
        chk("m1 trig count", count, 1);
        drive(0, 1, 4'hB, 0); step();
        chk("m1 cnt B", count, 2);
        drive(0, 0, 4'hF, 0); step();
        chk("m1 gap count", count, 2);
        drive(0, 1, 4'hC, 0); step();
        chk("m1 cnt C", count, 3);
        for (int i = 0; i < 13; i++) begin
            drive(0, 1, 4'(i), 0); step();
        end
        chk("m1 done", done, 1);
        chk("m1 trig_ts", trig_ts, 4);
        drive(0, 0, 0, 1); step();
        chk("m1 rd0", rd_data, 4'hA);
        step();
        chk("m1 rd1", rd_data, 4'hB);
        step();
        chk("m1 rd2", rd_data, 4'hC);
        chk("m1 rd2 valid", rd_valid, 1);

        // Mode 2: first sample and repeats never trigger; change to 9 does.
        trig_mode = 2'd2;
        drive(1, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'h5, 0); step();
            chk($sformatf("m2 rep%0d count", i), count, 0);
        end
        drive(0, 1, 4'h9, 0); step();
        chk("m2 trig count", count, 1);
        chk("m2 trig_ts", trig_ts, 4);
        for (int i = 0; i < 15; i++) begin
            drive(0, 1, 4'h5, 0); step();
        end
        chk("m2 done", done, 1);
        drive(0, 0, 0, 1); step();
        chk("m2 rd0", rd_data, 4'h9);
        chk("m2 rd0 valid", rd_valid, 1);

        // trig_ts saturation at 4 bits.
        trig_mode = 2'd1; trig_value = 4'hF;
        drive(1, 0, 0, 0); step();
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 4'h0, 0); step();
        end
        chk("sat pre count", count, 0);
        drive(0, 1, 4'hF, 0); step();
        chk("sat count", count, 1);
        chk("sat trig_ts", trig_ts, 15);

        // Async reset mid-capture after 5 stored samples.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 4'(i), 0); step();
        end
        chk("rst pre count", count, 5);
        drive(0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst count", count, 0);
        chk("rst rd_valid", rd_valid, 0);
        chk("rst trig_ts", trig_ts, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1); step();
            chk($sformatf("rst rd%0d valid", i), rd_valid, 0);
        end
        chk("rst idle done", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
